// File: rtl/systolic_pe_acc.sv
// systolic_pe_acc: output-stationary systolic MAC PE with operand forwarding and a valid/ready result.
// Build option PE_ACC_SAT_EN: saturating accumulation with a sticky sat_flag (wrap-around otherwise).
module systolic_pe_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 8,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  k_len,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_vld_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_vld_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_vld_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_vld_out,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  err,
  output logic                  sat_flag
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, klen_q, klen_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic err_q, err_d, sat_q, sat_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic av_q, bv_q;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic [2*DATA_WIDTH-1:0] prod_u;
  logic signed [ACC_WIDTH-1:0] ext_s;
  logic [ACC_WIDTH-1:0] ext_u, ext, sum, mac_val;
  logic mac, hs, can_start, ovf;
  assign prod_s = $signed(a_in) * $signed(b_in);
  assign prod_u = a_in * b_in;
  assign ext_s = prod_s;
  assign ext_u = ACC_WIDTH'(prod_u);
  assign ext = SIGNED ? ext_s : ext_u;
  assign sum = acc_q + ext;
`ifdef PE_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  // Signed overflow: operands agree in sign but the sum does not; unsigned: carry out wraps below acc.
  assign ovf = SIGNED ? ((acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                      : (sum < acc_q);
  assign mac_val = !ovf ? sum : SIGNED ? (acc_q[ACC_WIDTH-1] ? ~SMAX : SMAX) : '1;
`else
  assign ovf = 1'b0;
  assign mac_val = sum;
`endif
  assign mac = a_vld_in & b_vld_in;
  assign hs = (state_q == HOLD) & res_ready;
  assign can_start = start & ((state_q == IDLE) | hs);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    klen_d = klen_q;
    acc_d = acc_q;
    sat_d = sat_q;
    if (state_q == ACC && mac) begin
      acc_d = mac_val;
      cnt_d = cnt_q + CNT_WIDTH'(1);
      sat_d = sat_q | ovf;
      if (cnt_q == klen_q - CNT_WIDTH'(1)) state_d = HOLD;
    end
    if (hs) state_d = IDLE;
    if (can_start) begin
      klen_d = k_len;
      acc_d = '0;
      cnt_d = '0;
      state_d = (k_len == '0) ? HOLD : ACC;
    end
    err_d = err_q | (start & ~can_start) | (mac & (state_q != ACC));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      klen_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      av_q <= 1'b0;
      bv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      klen_q <= klen_d;
      acc_q <= acc_d;
      err_q <= err_d;
      sat_q <= sat_d;
      a_q <= a_vld_in ? a_in : a_q;
      b_q <= b_vld_in ? b_in : b_q;
      av_q <= a_vld_in;
      bv_q <= b_vld_in;
    end
  end
  assign a_out = a_q;
  assign b_out = b_q;
  assign a_vld_out = av_q;
  assign b_vld_out = bv_q;
  assign res_data = acc_q;
  assign res_valid = state_q == HOLD;
  assign busy = state_q == ACC;
  assign err = err_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_systolic_pe_acc.sv
// tb_systolic_pe_acc: directed vectors; expected results queued at issue, popped by monitors on handshake.
module tb_systolic_pe_acc;
  logic clk = 1'b0;
  logic rst;
  logic start, a_vld, b_vld, res_ready;
  logic [7:0] k_len;
  logic [15:0] a_in, b_in, a_out, b_out;
  logic a_vld_out, b_vld_out, res_valid, busy, err, sat_flag;
  logic [39:0] res_data;
  logic start2, a_vld2, b_vld2, res_ready2;
  logic [7:0] k_len2;
  logic [15:0] a2, b2, a_out2, b_out2;
  logic a_vld_out2, b_vld_out2, res_valid2, busy2, err2, sat2;
  logic [31:0] res_data2;
  logic [39:0] q1[$];
  logic [31:0] q2[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  systolic_pe_acc dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .a_in(a_in), .a_vld_in(a_vld), .b_in(b_in), .b_vld_in(b_vld),
    .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err(err), .sat_flag(sat_flag)
  );
  systolic_pe_acc #(.DATA_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8), .SIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .k_len(k_len2),
    .a_in(a2), .a_vld_in(a_vld2), .b_in(b2), .b_vld_in(b_vld2),
    .a_out(a_out2), .a_vld_out(a_vld_out2), .b_out(b_out2), .b_vld_out(b_vld_out2),
    .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready2),
    .busy(busy2), .err(err2), .sat_flag(sat2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pair(input logic [15:0] a, input logic [15:0] b);
    a_in = a; b_in = b; a_vld = 1'b1; b_vld = 1'b1;
    tick;
    a_vld = 1'b0; b_vld = 1'b0;
  endtask
  task automatic go(input logic [7:0] k);
    start = 1'b1; k_len = k;
    tick;
    start = 1'b0;
  endtask
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res1_unexpected: got %0h, required no result", res_data);
      end else chk("res1", res_data, q1.pop_front());
    end
    if (res_valid2 && res_ready2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res2_unexpected: got %0h, required no result", res_data2);
      end else chk("res2", res_data2, q2.pop_front());
    end
  end
  initial begin
    start = 0; k_len = 0; a_in = 0; b_in = 0; a_vld = 0; b_vld = 0; res_ready = 1;
    start2 = 0; k_len2 = 0; a2 = 0; b2 = 0; a_vld2 = 0; b_vld2 = 0; res_ready2 = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_outs", {res_data, res_valid, busy, err, sat_flag, a_vld_out, b_vld_out}, '0);
    chk("rst_fwd", {a_out, b_out}, '0);
    tick; tick;
    rst = 1'b1;
    tick;
    // signed dot product: 2*3 - 4*5 - 7 = -21
    q1.push_back(40'(-21));
    go(8'd3);
    chk("busy_acc", busy, 1);
    pair(16'd2, 16'd3);
    chk("fwd_a", {a_vld_out, a_out}, {1'b1, 16'd2});
    chk("fwd_b", {b_vld_out, b_out}, {1'b1, 16'd3});
    pair(-16'sd4, 16'd5);
    pair(16'd7, -16'sd1);
    chk("t1_hold", {res_valid, busy}, 2'b10);
    chk("fwd_last", {a_out, b_out}, {16'd7, 16'hFFFF});
    tick;
    chk("t1_idle", res_valid, 0);
    chk("fwd_vld_drop", {a_vld_out, b_vld_out, a_out}, {2'b00, 16'd7});
    // gapped pairs with a lone a_vld in between
    q1.push_back(40'd4);
    go(8'd4);
    pair(16'd1, 16'd1);
    tick;
    pair(16'd1, 16'd1);
    a_vld = 1'b1; a_in = 16'd9;
    tick;
    a_vld = 1'b0;
    tick;
    chk("t2_busy", {busy, res_valid}, 2'b10);
    pair(16'd1, 16'd1);
    chk("t2_busy5", busy, 1);
    pair(16'd1, 16'd1);
    chk("t2_hold", {res_valid, busy, err}, 3'b100);
    tick;
    // k_len = 0 held under backpressure, with a rejected start
    res_ready = 1'b0;
    q1.push_back(40'd0);
    go(8'd0);
    chk("t3_hold", {res_valid, res_data}, {1'b1, 40'd0});
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      k_len = 8'd7;
      tick;
      chk("t3_stable", {res_valid, busy, res_data}, {2'b10, 40'd0});
    end
    start = 1'b0;
    chk("t3_err", err, 1);
    // handshake and new start in the same cycle
    q1.push_back(40'd200);
    res_ready = 1'b1;
    go(8'd2);
    chk("b2b_acc", {busy, res_valid}, 2'b10);
    pair(16'd10, 16'd10);
    pair(16'd10, 16'd10);
    chk("b2b_hold", res_valid, 1);
    tick;
    // unsigned 16x16 into 32-bit accumulator
`ifdef PE_ACC_SAT_EN
    q2.push_back(32'hFFFF_FFFF);
`else
    q2.push_back(32'hFFFC_0002);
`endif
    start2 = 1'b1; k_len2 = 8'd2;
    tick;
    start2 = 1'b0;
    a2 = 16'hFFFF; b2 = 16'hFFFF; a_vld2 = 1'b1; b_vld2 = 1'b1;
    tick; tick;
    a_vld2 = 1'b0; b_vld2 = 1'b0;
`ifdef PE_ACC_SAT_EN
    chk("u_sat", {res_valid2, sat2, err2}, 3'b110);
`else
    chk("u_sat", {res_valid2, sat2, err2}, 3'b100);
`endif
    tick;
    chk("u_idle", res_valid2, 0);
    // reset in the middle of a tile discards the partial sum
    go(8'd5);
    pair(16'd1, 16'd2);
    pair(16'd3, 16'd4);
    a_vld = 1'b1; b_vld = 1'b1; a_in = 16'd5; b_in = 16'd6;
    #2 rst = 1'b0;
    #1;
    a_vld = 1'b0; b_vld = 1'b0;
    chk("mid_rst", {res_data, res_valid, busy, err, sat_flag, a_vld_out, b_vld_out, a_out, b_out}, '0);
    chk("mid_rst2", {res_data2, sat2, err2}, '0);
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_idle", {res_valid, busy, res_data}, '0);
    q1.push_back(40'd9);
    go(8'd1);
    pair(16'd3, 16'd3);
    chk("t6_hold", res_valid, 1);
    tick; tick;
    chk("q_drained", {32'(q1.size()), 32'(q2.size())}, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_pe_acc.md
Name: systolic_pe_acc

Overview:
Parametrised output-stationary systolic processing element, the next generation of our single-cycle MAC PE. It accumulates a programmable number of operand pairs into a wide accumulator, with signed or unsigned arithmetic. It forwards operands and valids to its right and down neighbours, and presents the finished dot product through a valid/ready result handshake. It is tiled into an R x C grid by the array top.

Parameters:
DATA_WIDTH, 16, operand width of A and B
ACC_WIDTH, 40, accumulator/result width; must be >= 2*DATA_WIDTH
CNT_WIDTH, 8, width of k_len and internal MAC counter
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: begin new tile, latch k_len, clear accumulator
k_len  in  CNT_WIDTH  number of MACs per tile (sampled on accepted start)
a_in  in  DATA_WIDTH  operand from left neighbour
a_vld_in  in  1  a_in valid
b_in  in  DATA_WIDTH  operand from upper neighbour
b_vld_in  in  1  b_in valid
a_out  out  DATA_WIDTH  registered a_in to right neighbour
a_vld_out  out  1  registered a_vld_in
b_out  out  DATA_WIDTH  registered b_in to lower neighbour
b_vld_out  out  1  registered b_vld_in
res_data  out  ACC_WIDTH  accumulated result
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
busy  out  1  high in ACC state
err  out  1  sticky: operand pair arrived while not in ACC, or start rejected
sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset (rst low, async): all outputs 0, accumulator 0, counter 0, state IDLE.
- Forwarding: a_out/b_out/valids register inputs every cycle, 1-cycle latency, independent of state. Data registers update only when the matching valid is high; valid registers update every cycle.
- MAC event: a_vld_in & b_vld_in both high in ACC. A lone valid is not a MAC and is not an error.
- Product: a_in*b_in at 2*DATA_WIDTH, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH unless saturation is compiled in.
- States:
  - IDLE: start -> latch k_len, acc=0, cnt=0. If k_len==0, go to HOLD with res_data=0; else go to ACC.
  - ACC: busy=1. On a MAC, acc+=product and cnt++. On the MAC where cnt==k_len-1, go to HOLD next cycle with res_data = final sum.
  - HOLD: res_valid=1, res_data stable. res_valid & res_ready -> IDLE.
- Back-to-back: start in the same cycle as a HOLD handshake is accepted as a new start (same rules as IDLE), so res_valid drops for 0 cycles only if the new k_len==0.
- Rejected start: start in ACC, or in HOLD without res_ready, is ignored and sets err.
- A MAC-valid pair in IDLE or HOLD is not accumulated and sets err.
- err and sat_flag clear only on reset.
- Latency: final MAC cycle -> res_valid high on the next edge.
- Reset mid-operation: immediate return to IDLE, partial sum discarded, no res_valid.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to the max/min of ACC_WIDTH (signed range if SIGNED=1, else 0..2^ACC_WIDTH-1), and sat_flag sets sticky. Once clamped, further MACs keep saturating arithmetic from the clamped value.
- Undefined: wrap-around arithmetic; sat_flag tied 0.

Test Plan:
- SIGNED=1, k_len=3, pairs (2,3),(-4,5),(7,-1) on consecutive cycles -> res_valid 1 cycle after third MAC, res_data=-21; res_ready=1 -> IDLE next cycle; a_out/b_out mirror inputs 1 cycle late.
- k_len=4 with gaps: valid pairs (1,1) on cycles 0,2,5,6, lone a_vld on cycle 3 -> res_data=4, err=0; busy high from start+1 until HOLD.
- k_len=0 start -> HOLD next cycle, res_data=0. Hold res_ready=0 for 5 cycles -> res_valid stays 1, data stable; start during that window -> ignored, err=1.
- Back-to-back: in HOLD assert res_ready and start with k_len=2 together -> next tile accumulates (10,10),(10,10) -> res_data=200.
- SIGNED=0, DATA_WIDTH=16, ACC_WIDTH=32, k_len=2, pairs (0xFFFF,0xFFFF) x2 -> with PE_ACC_SAT_EN res_data=0xFFFFFFFF, sat_flag=1; without it res_data=0xFFFC0002, sat_flag=0.
- Assert rst low mid-ACC after 2 of 5 MACs -> all outputs 0 immediately; new start k_len=1, pair (3,3) -> res_data=9.
